// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell plus a carry flip-flop,
// operands consumed LSB-first, result published WIDTH cycles after start.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_carry_n;
    logic             w_last;
    logic [WIDTH-1:0] w_res_n;

    assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_n = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // The A shift register doubles as the result register: each sum bit enters
    // at the MSB as the consumed operand bit leaves at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_res_n = w_s;
        end else begin : g_wn
            assign w_res_n = {w_s, r_a[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: every state register uses <= so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= w_res_n;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_n;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // On the MSB step r_carry is the carry into the MSB.
                        sum     <= w_res_n;
                        cout    <= w_carry_n;
                        ovf     <= r_carry ^ w_carry_n;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance driven from a vector
// table plus hand sequences, and a 1-bit instance for the half-adder cases.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start, cin, sub, busy, done, cout, ovf;
    logic [7:0] a, b, sum;

    logic       start1, cin1, sub1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one 8-bit op, scramble the inputs after acceptance, wait for done.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                         input logic tsub, output logic [7:0] rs, output logic rc,
                         output logic rv, output int lat, output int bc);
        rs  = 'x;
        rc  = 1'bx;
        rv  = 1'bx;
        lat = 0;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
        bc = busy ? 1 : 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n; rs = sum; rc = cout; rv = ovf;
                break;
            end
            if (busy) bc++;
        end
    endtask

    task automatic do_op1(input logic ta, input logic tb_v, output logic [1:0] res,
                          output int lat);
        res = 'x;
        lat = 0;
        @(negedge clk);
        a1 = ta; b1 = tb_v; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                lat = n; res = {cout1, sum1};
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] rs;
        logic       rc, rv;
        logic [1:0] r1;
        int         lat, bc, dcnt;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1};
        vecs[8] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, rv, lat, bc);
            check($sformatf("vec%0d_sum", i),  32'(rs),  32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(rc),  32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i),  32'(rv),  32'(vecs[i].ovf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd8);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // start pulsed mid-RUN with other operands must be ignored.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0;
        rs = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 3) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end
            if (done) begin
                dcnt++;
                rs = sum;
            end
        end
        check("busy_start_done_count", 32'(dcnt), 32'd1);
        check("busy_start_sum", 32'(rs), 32'h10);

        // Reset with cnt=4 aborts the op; no done afterwards.
        @(negedge clk);
        a = 8'h22; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        dcnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        do_op(8'h22, 8'h11, 1'b0, 1'b0, rs, rc, rv, lat, bc);
        check("after_abort_sum", 32'(rs), 32'h33);
        check("after_abort_latency", 32'(lat), 32'd8);

        // WIDTH=1: half-adder truth table.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic [1:0] exp1;
            ab = 2'(i);
            exp1 = 2'(ab[1]) + 2'(ab[0]);
            do_op1(ab[1], ab[0], r1, lat);
            check($sformatf("w1_%0d_result", i), 32'(r1), 32'(exp1));
            check($sformatf("w1_%0d_latency", i), 32'(lat), 32'd1);
        end

        // WIDTH=1 with start held: done every other cycle.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("w1_b2b_done_%0d", n), 32'(done1), 32'(n % 2));
            if (done1) check($sformatf("w1_b2b_res_%0d", n), 32'({cout1, sum1}), 32'd2);
        end
        start1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
